adc_pulse_source: RTL and testbench
===================================

// Module: adc_pulse_source
// PURPOSE
// Synthesises detector-like ADC samples: on each accepted trigger it adds a pulse
// with a linear leading edge and an exponential tail to a baseline. It is the
// signal source for the trapezoidal shaping filter, for closed-loop test and
// on-chip self-check. Its decay constant 2^DECAY_SHIFT is what the filter's M
// parameter must cancel.
// PARAMETERS
// DATA_W      12   ADC sample width, unsigned
// FRAC_W      8    fractional bits of the internal accumulator
// DECAY_SHIFT 4    tail decay per sample: acc -= acc>>>DECAY_SHIFT (tau ~ 2^DECAY_SHIFT)
// RISE_SHIFT  2    rise length = 2^RISE_SHIFT samples; requires RISE_SHIFT <= FRAC_W
// BASELINE    100  constant offset added to every output sample, < 2^DATA_W
// PORTS
// clk         in   1       clock
// reset       in   1       synchronous, active-low
// sample_en   in   1       sample strobe; acc and adc_data advance only when 1
// trig_valid  in   1       pulse request
// trig_amp    in   DATA_W  pulse amplitude in ADC counts
// trig_ready  out  1       request accepted on a clk edge where valid&&ready
// adc_data    out  DATA_W  synthesised sample, registered
// busy        out  1       state != IDLE
// pulse_cnt   out  16      accepted-trigger counter, wraps 0xFFFF->0
// BEHAVIOUR
// - acc: unsigned, DATA_W+1 integer bits + FRAC_W fraction bits. int(acc) = acc>>FRAC_W.
// - Reset (reset==0 at posedge): state=IDLE, acc=0, amp_reg=0, step_cnt=0,
//   adc_data=BASELINE, pulse_cnt=0. trig_ready=0 while reset==0.
// - trig_ready = (state==IDLE || state==DECAY) && reset==1. Combinational from state.
// - Acceptance happens on any clk edge, independent of sample_en. It latches
//   step = trig_amp<<(FRAC_W-RISE_SHIFT), sets step_cnt=0, state->RISE, pulse_cnt+1.
// - FSM, advances on sample_en edges:
//   IDLE : acc held at 0. On accept -> RISE.
//   RISE : acc += step (saturating at all-ones), no decay, step_cnt++.
//          After 2^RISE_SHIFT steps -> DECAY. Net rise is exactly trig_amp.
//   DECAY: acc -= acc>>DECAY_SHIFT.
//          If int(acc_next)==0 -> IDLE and acc cleared to 0. On accept -> RISE (pile-up).
// - A trigger accepted during DECAY keeps the residual acc. The new edge stacks on
//   the tail.
// - Accept and the DECAY->IDLE condition on the same edge: the trigger wins. State
//   goes to RISE, acc is not cleared, and the decay for that edge still applies.
// - A trigger accepted on a non-sample_en edge takes its first step at the next
//   sample_en edge.
// - trig_amp=0 is legal: full RISE with zero step, then DECAY, which goes straight to IDLE.
// - adc_data <= min(BASELINE + int(acc_next), 2^DATA_W-1) on sample_en edges.
//   Output reflects the acc update of the same edge, 0 cycles after it.
// - sample_en=0: acc, adc_data, step_cnt and state hold, except for trigger acceptance.
// - Reset mid-pulse returns to reset values on that edge; no partial pulse resumes.
// TESTING (DATA_W=12, FRAC_W=8, DECAY_SHIFT=4, RISE_SHIFT=2, BASELINE=100)
// 1 reset low 3 clks, sample_en=1 -> adc_data=100, busy=0, trig_ready=0, then 1
//   after release, pulse_cnt=0.
// 2 accept amp=400 at edge t, sample_en=1 -> adc_data 200,300,400,500 at t+1..t+4,
//   then 475,451 (acc 375.0, 351.5625), busy=1, pulse_cnt=1.
// 3 trig_valid held from t+1 during RISE -> trig_ready=0 for t+1..t+4, accepted
//   first DECAY edge; new edge stacks onto ~500.
// 4 two amp=4095 pulses back-to-back -> adc_data clamps at 4095, no wrap, acc
//   never overflows.
// 5 single amp=400, wait -> adc_data decays monotonically to 100 and busy falls
//   on the edge int(acc) reaches 0, trig_ready stays 1.
// 6 sample_en 1-in-4, reset low mid-RISE -> outputs change only on strobes;
//   reset edge gives adc_data=100, state IDLE, pulse_cnt=0.

Source files
------------

// File: rtl/adc_pulse_source_if.sv
// Bus bundle for adc_pulse_source: trigger handshake, sample strobe and synthesised outputs.
// Handshake: a trigger transfers on a clk edge where trig_valid && trig_ready; trig_valid may
// be held across edges and trig_amp must be stable while it is high. trig_ready is decoded from state.
interface adc_pulse_source_if #(
  parameter int DATA_W = 12
);
  logic              sample_en;
  logic              trig_valid;
  logic [DATA_W-1:0] trig_amp;
  logic              trig_ready;
  logic [DATA_W-1:0] adc_data;
  logic              busy;
  logic [15:0]       pulse_cnt;
  logic [1:0]        state_dbg;

  modport master (
    output sample_en, trig_valid, trig_amp,
    input  trig_ready, adc_data, busy, pulse_cnt, state_dbg
  );

  modport slave (
    input  sample_en, trig_valid, trig_amp,
    output trig_ready, adc_data, busy, pulse_cnt, state_dbg
  );
endinterface

// File: rtl/adc_pulse_source.sv
// Detector-like ADC sample synthesiser: linear rise of 2^RISE_SHIFT samples followed by an
// exponential tail (tau ~ 2^DECAY_SHIFT) on top of a constant baseline, with pile-up support.
module adc_pulse_source #(
  parameter int DATA_W      = 12,
  parameter int FRAC_W      = 8,
  parameter int DECAY_SHIFT = 4,
  parameter int RISE_SHIFT  = 2,
  parameter int BASELINE    = 100
) (
  input  logic               clk,
  input  logic               reset,
  adc_pulse_source_if.slave  bus
);

  localparam int ACC_W    = DATA_W + 1 + FRAC_W;
  localparam int INT_W    = DATA_W + 1;
  localparam int STEP_SH  = FRAC_W - RISE_SHIFT;
  localparam int CNT_W    = RISE_SHIFT + 1;
  localparam int RISE_LEN = 1 << RISE_SHIFT;

  localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'(RISE_LEN - 1);
  localparam logic [DATA_W+1:0] BASE_EXT  = (DATA_W + 2)'(BASELINE);
  localparam logic [DATA_W+1:0] ADC_MAX   = (DATA_W + 2)'((1 << DATA_W) - 1);
  localparam logic [DATA_W-1:0] ADC_RST   = DATA_W'(BASELINE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  amp_reg;
  logic [CNT_W-1:0]  step_cnt;
  logic [CNT_W-1:0]  step_cnt_next;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] adc_next;
  logic [15:0]       pulse_cnt;

  logic              trig_ready;
  logic              accept;
  logic [ACC_W:0]    rise_sum;
  logic [ACC_W-1:0]  rise_acc;
  logic [ACC_W-1:0]  decay_acc;
  logic              decay_int_zero;
  logic [INT_W-1:0]  acc_next_int;
  logic [DATA_W+1:0] base_sum;

  assign trig_ready = ((state == IDLE) || (state == DECAY)) && reset;
  assign accept     = bus.trig_valid && trig_ready;

  // Rise saturates at all-ones so stacked full-scale pulses can never wrap the accumulator.
  assign rise_sum       = {1'b0, acc} + {1'b0, amp_reg};
  assign rise_acc       = rise_sum[ACC_W] ? {ACC_W{1'b1}} : rise_sum[ACC_W-1:0];
  assign decay_acc      = acc - (acc >> DECAY_SHIFT);
  assign decay_int_zero = (decay_acc[ACC_W-1:FRAC_W] == '0);

  always_comb begin
    acc_next = acc;
    if (bus.sample_en) begin
      case (state)
        IDLE:    acc_next = '0;
        RISE:    acc_next = rise_acc;
        DECAY:   acc_next = (decay_int_zero && !accept) ? '0 : decay_acc;
        default: acc_next = '0;
      endcase
    end
  end

  // A trigger always wins over the tail reaching zero; the decay of that edge still lands.
  always_comb begin
    state_next    = state;
    step_cnt_next = step_cnt;
    if (accept) begin
      state_next    = RISE;
      step_cnt_next = '0;
    end else if (bus.sample_en) begin
      case (state)
        RISE: begin
          if (step_cnt == RISE_LAST) begin
            state_next    = DECAY;
            step_cnt_next = '0;
          end else begin
            step_cnt_next = step_cnt + 1'b1;
          end
        end
        DECAY: begin
          if (decay_int_zero) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign acc_next_int = acc_next[ACC_W-1:FRAC_W];
  assign base_sum     = BASE_EXT + {1'b0, acc_next_int};
  assign adc_next     = (base_sum > ADC_MAX) ? ADC_MAX[DATA_W-1:0] : base_sum[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      amp_reg   <= '0;
      step_cnt  <= '0;
      adc_data  <= ADC_RST;
      pulse_cnt <= '0;
    end else begin
      state    <= state_next;
      step_cnt <= step_cnt_next;
      if (bus.sample_en) begin
        acc      <= acc_next;
        adc_data <= adc_next;
      end
      if (accept) begin
        amp_reg   <= ACC_W'(bus.trig_amp) << STEP_SH;
        pulse_cnt <= pulse_cnt + 16'd1;
      end
    end
  end

  assign bus.trig_ready = trig_ready;
  assign bus.adc_data   = adc_data;
  assign bus.busy       = (state != IDLE);
  assign bus.pulse_cnt  = pulse_cnt;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_adc_pulse_source.sv
// Directed bench for adc_pulse_source: driver pushes the expected post-edge outputs,
// a monitor pops and compares them one step after every clock edge.
module tb_adc_pulse_source;

  localparam int W = 30;

  logic clk;
  logic reset;

  adc_pulse_source_if #(.DATA_W(12)) bus ();

  adc_pulse_source #(
    .DATA_W(12), .FRAC_W(8), .DECAY_SHIFT(4), .RISE_SHIFT(2), .BASELINE(100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run = 0;
  int           failures  = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset          = 1'b0;
    bus.sample_en  = 1'b0;
    bus.trig_valid = 1'b0;
    bus.trig_amp   = '0;
  end

  // monitor / scoreboard: outputs are compared 1 time unit after each active edge
  always @(posedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        nm;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.adc_data, bus.busy, bus.trig_ready, bus.pulse_cnt};
      tests_run++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s: got adc=%0d busy=%0b ready=%0b cnt=%0d, expected adc=%0d busy=%0b ready=%0b cnt=%0d",
                 nm, got[29:18], got[17], got[16], got[15:0],
                 exp[29:18], exp[17], exp[16], exp[15:0]);
      end
    end
  end

  // driver: one call = one clock edge with its expected outcome
  task automatic cyc(input logic rst, input logic se, input logic tv, input logic [11:0] amp,
                     input logic [11:0] e_adc, input logic e_busy, input logic e_ready,
                     input logic [15:0] e_cnt, input string nm);
    @(negedge clk);
    reset          = rst;
    bus.sample_en  = se;
    bus.trig_valid = tv;
    bus.trig_amp   = amp;
    exp_q.push_back({e_adc, e_busy, e_ready, e_cnt});
    name_q.push_back(nm);
  endtask

  // reference tail: acc -= acc>>4 in 8-bit fixed point until the integer part is zero
  task automatic decay_tail(input int start_acc, input logic [15:0] cnt, input string nm);
    int   a;
    int   adc;
    logic done;
    a    = start_acc;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      a = a - (a >> 4);
      if ((a >> 8) == 0) begin
        a    = 0;
        done = 1'b1;
      end
      adc = 100 + (a >> 8);
      if (adc > 4095) adc = 4095;
      cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'(adc), !done, 1'b1, cnt, nm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state and release
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 12'd0, 12'd100, 1'b0, 1'b0, 16'd0, "reset");
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd100, 1'b0, 1'b1, 16'd0, "release");

    // single amp=400 pulse, then full tail to idle
    cyc(1'b1, 1'b1, 1'b1, 12'd400, 12'd100, 1'b1, 1'b0, 16'd1, "p1_accept");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd200, 1'b1, 1'b0, 16'd1, "p1_rise1");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd300, 1'b1, 1'b0, 16'd1, "p1_rise2");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd400, 1'b1, 1'b0, 16'd1, "p1_rise3");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd500, 1'b1, 1'b1, 16'd1, "p1_rise4");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd475, 1'b1, 1'b1, 16'd1, "p1_decay1");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd451, 1'b1, 1'b1, 16'd1, "p1_decay2");
    decay_tail(90000, 16'd1, "p1_tail");

    // trigger held through rise, accepted on first decay edge (pile-up)
    cyc(1'b1, 1'b1, 1'b1, 12'd400, 12'd100, 1'b1, 1'b0, 16'd2, "pu_accept");
    cyc(1'b1, 1'b1, 1'b1, 12'd200, 12'd200, 1'b1, 1'b0, 16'd2, "pu_hold1");
    cyc(1'b1, 1'b1, 1'b1, 12'd200, 12'd300, 1'b1, 1'b0, 16'd2, "pu_hold2");
    cyc(1'b1, 1'b1, 1'b1, 12'd200, 12'd400, 1'b1, 1'b0, 16'd2, "pu_hold3");
    cyc(1'b1, 1'b1, 1'b1, 12'd200, 12'd500, 1'b1, 1'b1, 16'd2, "pu_hold4");
    cyc(1'b1, 1'b1, 1'b1, 12'd200, 12'd475, 1'b1, 1'b0, 16'd3, "pu_stack");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd525, 1'b1, 1'b0, 16'd3, "pu_rise1");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd575, 1'b1, 1'b0, 16'd3, "pu_rise2");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd625, 1'b1, 1'b0, 16'd3, "pu_rise3");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd675, 1'b1, 1'b1, 16'd3, "pu_rise4");
    decay_tail(147200, 16'd3, "pu_tail");

    // full-scale pulses: output clamps, accumulator saturates instead of wrapping
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 12'd100,  1'b1, 1'b0, 16'd4, "fs_accept1");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,    12'd1123, 1'b1, 1'b0, 16'd4, "fs_rise1");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,    12'd2147, 1'b1, 1'b0, 16'd4, "fs_rise2");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,    12'd3171, 1'b1, 1'b0, 16'd4, "fs_rise3");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,    12'd4095, 1'b1, 1'b1, 16'd4, "fs_rise4");
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 12'd3939, 1'b1, 1'b0, 16'd5, "fs_accept2");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd4095, 1'b1, 1'b0, 16'd5, "fs_clamp");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,    12'd4095, 1'b1, 1'b1, 16'd5, "fs_clamp_end");
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 12'd4095, 1'b1, 1'b0, 16'd6, "fs_accept3");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd4095, 1'b1, 1'b0, 16'd6, "fs_sat");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,    12'd4095, 1'b1, 1'b1, 16'd6, "fs_sat_end");
    decay_tail(2097151, 16'd6, "fs_tail");

    // zero amplitude, with a trigger landing on the edge the tail would go idle
    cyc(1'b1, 1'b1, 1'b1, 12'd0, 12'd100, 1'b1, 1'b0, 16'd7, "z_accept");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd100, 1'b1, 1'b0, 16'd7, "z_rise");
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd100, 1'b1, 1'b1, 16'd7, "z_rise_end");
    cyc(1'b1, 1'b1, 1'b1, 12'd0, 12'd100, 1'b1, 1'b0, 16'd8, "z_trig_wins");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd100, 1'b1, 1'b0, 16'd8, "z_rise_b");
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd100, 1'b1, 1'b1, 16'd8, "z_rise_b_end");
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd100, 1'b0, 1'b1, 16'd8, "z_idle");

    // sparse strobes, accept off-strobe, reset in the middle of the rise
    cyc(1'b1, 1'b0, 1'b1, 12'd400, 12'd100, 1'b1, 1'b0, 16'd9, "s_accept_nostrobe");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 12'd0, 12'd100, 1'b1, 1'b0, 16'd9, "s_hold0");
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd200, 1'b1, 1'b0, 16'd9, "s_strobe1");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 12'd0, 12'd200, 1'b1, 1'b0, 16'd9, "s_hold1");
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd300, 1'b1, 1'b0, 16'd9, "s_strobe2");
    cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd100, 1'b0, 1'b0, 16'd0, "s_reset_mid_rise");
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd100, 1'b0, 1'b1, 16'd0, "s_after_reset");
    cyc(1'b1, 1'b1, 1'b1, 12'd400, 12'd100, 1'b1, 1'b0, 16'd1, "s_restart");
    cyc(1'b1, 1'b1, 1'b0, 12'd0,   12'd200, 1'b1, 1'b0, 16'd1, "s_restart_rise1");

    @(negedge clk);
    bus.trig_valid = 1'b0;
    bus.sample_en  = 1'b0;
    @(posedge clk);
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
